mem_port_arbiter: RTL

//  Shares one single-ported unified memory between the pipeline's fetch port (I) and load/store port (D).

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter_arb_rr2.sv | 20 ++
 rtl/mem_port_arbiter.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the I/D unified-memory port arbiter:
// FSM state encoding and port-owner encoding.
package mem_port_arbiter_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GNT_I = 2'd1;
    localparam logic [1:0] ST_GNT_D = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef logic owner_t;

    localparam owner_t OWN_I = 1'b0;
    localparam owner_t OWN_D = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and memory-side handshake
// signals seen by mem_port_arbiter. The slave modport is the arbiter's
// view; the master modport is the view of the pipeline and memory around it.
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic              i_req;
    logic [AW-1:0]     i_addr;
    logic [DW-1:0]     i_rdata;
    logic              i_ack;

    logic              d_req;
    logic              d_we;
    logic [DW/8-1:0]   d_be;
    logic [AW-1:0]     d_addr;
    logic [DW-1:0]     d_wdata;
    logic [DW-1:0]     d_rdata;
    logic              d_ack;

    logic              err;

    logic              mem_req;
    logic              mem_we;
    logic [DW/8-1:0]   mem_be;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;
    logic              mem_ack;

    modport slave (
        input  i_req, i_addr,
        output i_rdata, i_ack,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_rdata, d_ack,
        output err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport master (
        output i_req, i_addr,
        input  i_rdata, i_ack,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_rdata, d_ack,
        input  err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Two-way fair arbiter: a lone requester wins; when both request, the port
// that did not own the memory last time wins. Grant is one-hot, indexed by
// owner encoding (bit OWN_I = fetch, bit OWN_D = load/store).
module arb_rr2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  owner_t     last_owner_i,
    output logic [1:0] gnt_o
);

    // Alternate on contention so neither port can starve the other.
    always_comb begin
        gnt_o = req_i;
        if (req_i[OWN_I] && req_i[OWN_D]) begin
            gnt_o = (last_owner_i == OWN_I) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the fetch (I) and load/store (D)
// ports with one outstanding access at a time.
// Optional feature: define MEMARB_TIMEOUT_EN to abort an access that waits
// TMO_CYC cycles for mem_ack (ack returned with err=1, rdata=0).
//
//   state    | meaning
//   ---------+----------------------------------------------------------
//   ST_IDLE  | no access in flight; arbitrate and latch winner's request
//   ST_GNT_I | fetch access on the memory bus, waiting for mem_ack
//   ST_GNT_D | load/store access on the memory bus, waiting for mem_ack
//   ST_RESP  | one-cycle ack to the owner; owner's req ignored here
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TMO_CYC = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.slave    bus
);

    localparam int BW = DW / 8;

    if (TMO_CYC < 1) begin : g_tmo_check
        $error("TMO_CYC must be at least 1");
    end

    logic [1:0]    state_q, state_d;
    owner_t        owner_q, owner_d;
    owner_t        last_owner_q, last_owner_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [BW-1:0] mem_be_q, mem_be_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] i_rdata_q, i_rdata_d;
    logic [DW-1:0] d_rdata_q, d_rdata_d;
    logic          err_q, err_d;
    logic [1:0]    gnt;
    logic          in_gnt;
    logic          tmo_hit;

    assign in_gnt = (state_q == ST_GNT_I) || (state_q == ST_GNT_D);

    arb_rr2 u_arb (
        .req_i        ({bus.d_req, bus.i_req}),
        .last_owner_i (last_owner_q),
        .gnt_o        (gnt)
    );

`ifdef MEMARB_TIMEOUT_EN
    localparam int CW = ($clog2(TMO_CYC + 1) > 8) ? $clog2(TMO_CYC + 1) : 8;

    logic [CW-1:0] cnt_q, cnt_d;

    // The access has spent TMO_CYC cycles in GNT when this cycle ends.
    assign tmo_hit = (cnt_q == CW'(TMO_CYC - 1));

    // Count cycles spent waiting in GNT; cleared whenever idle.
    always_comb begin
        cnt_d = '0;
        if (in_gnt) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Grant FSM plus memory-request and read-data capture datapath.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_be_d     = mem_be_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        err_d        = err_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt[OWN_D]) begin
                    state_d     = ST_GNT_D;
                    owner_d     = OWN_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = bus.d_we;
                    mem_be_d    = bus.d_be;
                    mem_addr_d  = bus.d_addr;
                    mem_wdata_d = bus.d_wdata;
                end else if (gnt[OWN_I]) begin
                    state_d     = ST_GNT_I;
                    owner_d     = OWN_I;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_be_d    = '1;
                    mem_addr_d  = bus.i_addr;
                    mem_wdata_d = '0;
                end
            end
            ST_GNT_I, ST_GNT_D: begin
                if (bus.mem_ack) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    if (owner_q == OWN_I) begin
                        i_rdata_d = bus.mem_rdata;
                    end else begin
                        d_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
                    end
                end else if (tmo_hit) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (owner_q == OWN_I) begin
                        i_rdata_d = '0;
                    end else begin
                        d_rdata_d = '0;
                    end
                end
            end
            ST_RESP: begin
                state_d      = ST_IDLE;
                last_owner_d = owner_q;
                err_d        = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears every visible output.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_I;
            last_owner_q <= OWN_I;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_be_q     <= mem_be_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            err_q        <= err_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.i_ack     = (state_q == ST_RESP) && (owner_q == OWN_I);
    assign bus.d_ack     = (state_q == ST_RESP) && (owner_q == OWN_D);
    assign bus.err       = err_q;

endmodule
